// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and pin indices for the bit-serial subtractor
package serial_sub_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // uio_in control bits
    localparam int LOAD_A = 0;
    localparam int LOAD_B = 1;
    localparam int START  = 2;
    localparam int MODE   = 3;

    // uio_out status bits
    localparam int BUSY   = 4;
    localparam int DONE   = 5;
    localparam int BORROW = 6;
    localparam int ZERO   = 7;

endpackage

// File: rtl/serial_sub_bitcell.sv
// rtl/serial_sub_bitcell.sv - one-bit full subtractor; full adder on mode=1 when SERIAL_SUB_ADD_EN is defined
module serial_sub_bitcell (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    input  logic mode,
    output logic d,
    output logic borrow_out
);

`ifdef SERIAL_SUB_ADD_EN
    always_comb begin
        d = a ^ b ^ borrow_in;
        if (mode) begin
            borrow_out = (a & b) | (borrow_in & (a ^ b));
        end else begin
            borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign d           = a ^ b ^ borrow_in;
    assign borrow_out  = (~a & b) | (~(a ^ b) & borrow_in);
`endif

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor top; SERIAL_SUB_ADD_EN adds a serial add mode
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               zero_q, zero_d;
    logic               mode_q, mode_d;
    logic               cell_d, cell_br;
    logic [WIDTH-1:0]   res_shift;
    logic [3:0]         unused_uio;

    assign unused_uio = uio_in[7:4];

    serial_sub_bitcell u_bitcell (
        .a          (a_q[0]),
        .b          (b_q[0]),
        .borrow_in  (br_q),
        .mode       (mode_q),
        .d          (cell_d),
        .borrow_out (cell_br)
    );

    assign res_shift = {cell_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_ADD_EN
    assign mode_d = (ena && state_q != ST_RUN && uio_in[START]) ? uio_in[MODE] : mode_q;
`else
    logic unused_mode;
    assign unused_mode = uio_in[MODE];
    assign mode_d      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        zero_d  = zero_q;
        if (ena) begin
            case (state_q)
                ST_RUN: begin
                    // Operands rotate rather than shift so a restart from DONE reuses them.
                    a_d   = {a_q[0], a_q[WIDTH-1:1]};
                    b_d   = {b_q[0], b_q[WIDTH-1:1]};
                    res_d = res_shift;
                    br_d  = cell_br;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                        zero_d  = (res_shift == '0);
                    end
                end
                default: begin
                    if (uio_in[START]) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        br_d    = 1'b0;
                        res_d   = '0;
                        zero_d  = 1'b0;
                    end else begin
                        if (uio_in[LOAD_A]) a_d = WIDTH'(ui_in);
                        if (uio_in[LOAD_B]) b_d = WIDTH'(ui_in);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            zero_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            zero_q  <= zero_d;
            mode_q  <= mode_d;
        end
    end

    // The borrow flop is only meaningful once the run has finished.
    always_comb begin
        uio_out         = 8'h00;
        uio_out[BUSY]   = (state_q == ST_RUN);
        uio_out[DONE]   = (state_q == ST_DONE);
        uio_out[BORROW] = (state_q == ST_DONE) && br_q;
        uio_out[ZERO]   = zero_q;
    end

    assign uo_out = 8'(res_q);
    assign uio_oe = 8'hF0;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with directed vectors
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    serial_subtractor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] uo;
        logic       br;
        logic       z;
        int         busy_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic done_prev = 1'b0;
    int   busy_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: completes a transaction on the rising edge of done.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (uio_out[4]) busy_cnt++;
            if (uio_out[5] && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("uo_out",     uo_out,     mon_e.uo);
                    check("borrow",     uio_out[6], mon_e.br);
                    check("zero",       uio_out[7], mon_e.z);
                    check("busy_clear", uio_out[4], 0);
                    check("low_nibble", uio_out[3:0], 0);
                    check("busy_cycles", busy_cnt,  mon_e.busy_cyc);
                end
                busy_cnt = 0;
            end else if (!uio_out[4]) begin
                busy_cnt = 0;
            end
            done_prev = uio_out[5];
        end
    end

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        ui_in = a; uio_in = 8'h01;
        @(negedge clk);
        ui_in = b; uio_in = 8'h02;
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic start_raw(input logic mode, input logic [7:0] extra);
        uio_in = extra | {4'b0, mode, 3'b100};
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic start_op(input logic mode, input logic [7:0] uo, input logic br,
                            input logic z, input int cyc);
        exp_t e;
        e.uo = uo; e.br = br; e.z = z; e.busy_cyc = cyc;
        sb.push_back(e);
        start_raw(mode, 8'h00);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!uio_out[5] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check({name, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_uo_out",  uo_out,  8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe",  uio_oe,  8'hF0);
        rst_n = 1'b1;
        @(negedge clk);
        check("uio_oe_run", uio_oe, 8'hF0);

        load_ab(8'h05, 8'h03);
        start_op(1'b0, 8'h02, 1'b0, 1'b0, 8);
        wait_done("sub_05_03");

        load_ab(8'h03, 8'h05);
        start_op(1'b0, 8'hFE, 1'b1, 1'b0, 8);
        wait_done("sub_03_05");

        // Both loads together capture the same byte.
        ui_in = 8'hA5; uio_in = 8'h03;
        @(negedge clk);
        uio_in = 8'h00;
        start_op(1'b0, 8'h00, 1'b0, 1'b1, 8);
        wait_done("sub_a5_a5");
        start_op(1'b0, 8'h00, 1'b0, 1'b1, 8);
        wait_done("rerun_a5");

        // Load coincident with start is dropped.
        ui_in = 8'h00;
        sb.push_back('{uo: 8'h00, br: 1'b0, z: 1'b1, busy_cyc: 8});
        start_raw(1'b0, 8'h01);
        wait_done("start_priority");

        load_ab(8'h10, 8'h01);
        start_op(1'b0, 8'h0F, 1'b0, 1'b0, 8);
        repeat (2) @(negedge clk);
        ui_in = 8'hFF; uio_in = 8'h05;
        @(negedge clk);
        uio_in = 8'h00;
        wait_done("run_disturb");

        start_op(1'b0, 8'h0F, 1'b0, 1'b0, 13);
        @(negedge clk);
        ena = 1'b0;
        ui_in = 8'hFF; uio_in = 8'h03;
        repeat (5) @(negedge clk);
        uio_in = 8'h00;
        ena = 1'b1;
        wait_done("ena_hold");

        start_raw(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_uo_out",  uo_out,  8'h00);
        check("midrst_uio_out", uio_out, 8'h00);
        check("midrst_uio_oe",  uio_oe,  8'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load_ab(8'h80, 8'h7F);
        start_op(1'b0, 8'h01, 1'b0, 1'b0, 8);
        wait_done("post_reset");

        load_ab(8'h00, 8'h01);
        start_op(1'b0, 8'hFF, 1'b1, 1'b0, 8);
        wait_done("sub_00_01");

        load_ab(8'hFF, 8'h01);
`ifdef SERIAL_SUB_ADD_EN
        start_op(1'b1, 8'h00, 1'b1, 1'b1, 8);
        wait_done("add_ff_01");
        start_op(1'b0, 8'hFE, 1'b0, 1'b0, 8);
        wait_done("sub_ff_01");
`else
        start_op(1'b1, 8'hFE, 1'b0, 1'b0, 8);
        wait_done("mode_ignored");
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
